// File: rtl/pb_input_conditioner_if.sv
// rtl/pb_input_conditioner_if.sv - pushbutton conditioner signal bundle
//
// Purpose: groups the raw button inputs, the uP read strobe and the
//          conditioned button outputs of pb_input_conditioner.
// Signals:
//   pb_raw     [WIDTH] raw, asynchronous, bounce-prone buttons
//   rd_strobe  [1]     uP input-read pulse, clears pb_latched
//   pb_level   [WIDTH] debounced level, 1 = pressed
//   pb_press   [WIDTH] one-cycle pulse on a debounced rising edge
//   pb_latched [WIDTH] sticky press capture, cleared by rd_strobe
//   pb_any     [1]     registered OR of pb_latched
// Modports:
//   master - board/uP side (drives pb_raw, rd_strobe)
//   slave  - conditioner side (drives the conditioned outputs)

interface pb_input_conditioner_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] pb_raw;
  logic             rd_strobe;
  logic [WIDTH-1:0] pb_level;
  logic [WIDTH-1:0] pb_press;
  logic [WIDTH-1:0] pb_latched;
  logic             pb_any;

  modport master (
    output pb_raw,
    output rd_strobe,
    input  pb_level,
    input  pb_press,
    input  pb_latched,
    input  pb_any
  );

  modport slave (
    input  pb_raw,
    input  rd_strobe,
    output pb_level,
    output pb_press,
    output pb_latched,
    output pb_any
  );
endinterface

// File: rtl/pb_input_conditioner.sv
// rtl/pb_input_conditioner.sv - pushbutton synchroniser, debouncer and press latch
//
// Purpose: per button bit, a 2-flop synchroniser followed by a counter-based
//          debounce FSM. Produces a clean level, a one-cycle press pulse and
//          a sticky press latch that the uP clears with rd_strobe.
// Parameters:
//   WIDTH     number of independent button channels
//   DB_CYCLES consecutive synchronised samples needed to accept a change (2..255)
//   CNT_W     debounce counter width, 2**CNT_W > DB_CYCLES
// Ports:
//   clock  rising-edge system clock
//   reset  synchronous, active-high reset
//   pb     pb_input_conditioner_if.slave (pb_raw, rd_strobe in;
//          pb_level, pb_press, pb_latched, pb_any out)
// Build option:
//   PB_ACTIVE_LOW_EN  defined: buttons are active-low (pull-up boards);
//                     outputs still use 1 = pressed.

module pb_input_conditioner #(
  parameter int WIDTH     = 4,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  pb_input_conditioner_if.slave  pb
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Synchroniser stages hold the raw board level; the reset value is the
  // idle (released) level so that a released button never starts a debounce
  // right after reset.
`ifdef PB_ACTIVE_LOW_EN
  localparam logic [WIDTH-1:0] SYNC_IDLE = '1;
`else
  localparam logic [WIDTH-1:0] SYNC_IDLE = '0;
`endif

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] pressed_s;   // synchronised, 1 = pressed

  state_t           state_q [WIDTH];
  state_t           state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];

  logic [WIDTH-1:0] level_q,   level_d;
  logic [WIDTH-1:0] press_q,   press_d;
  logic [WIDTH-1:0] latched_q, latched_d;
  logic             any_q;

  // ---------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= SYNC_IDLE;
      sync2 <= SYNC_IDLE;
    end else begin
      sync1 <= pb.pb_raw;
      sync2 <= sync1;
    end
  end

`ifdef PB_ACTIVE_LOW_EN
  assign pressed_s = ~sync2;
`else
  assign pressed_s = sync2;
`endif

  // ---------------------------------------------------------------------
  // Debounce FSM state registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= STABLE_LO;
        cnt_q[i]   <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      latched_q <= '0;
      any_q     <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q   <= level_d;
      press_q   <= press_d;
      latched_q <= latched_d;
      // pb_any deliberately lags pb_latched by one cycle.
      any_q     <= |latched_q;
    end
  end

  // ---------------------------------------------------------------------
  // Debounce FSM next-state / output logic
  // ---------------------------------------------------------------------
  // cnt counts synchronised samples of the candidate value seen so far; the
  // first one is counted on the transition into WAIT_*, so acceptance happens
  // on the DB_CYCLES-th consecutive sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = '0;

    for (int i = 0; i < WIDTH; i++) begin
      case (state_q[i])
        STABLE_LO: begin
          if (pressed_s[i]) begin
            state_d[i] = WAIT_HI;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i]   = '0;
          end
        end

        WAIT_HI: begin
          if (!pressed_s[i]) begin
            state_d[i] = STABLE_LO;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = STABLE_HI;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end

        STABLE_HI: begin
          if (!pressed_s[i]) begin
            state_d[i] = WAIT_LO;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i]   = '0;
          end
        end

        WAIT_LO: begin
          if (pressed_s[i]) begin
            state_d[i] = STABLE_HI;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = STABLE_LO;
            cnt_d[i]   = '0;
            level_d[i] = 1'b0;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end

        default: begin
          state_d[i] = STABLE_LO;
          cnt_d[i]   = '0;
        end
      endcase
    end

    // A press accepted on the same edge as a read wins, so no press is lost.
    latched_d = (pb.rd_strobe ? '0 : latched_q) | press_d;
  end

  assign pb.pb_level   = level_q;
  assign pb.pb_press   = press_q;
  assign pb.pb_latched = latched_q;
  assign pb.pb_any     = any_q;

endmodule
